mdu_sequencer: RTL and testbench

Iterative multiply/divide unit with its own sequencing FSM for the 54-instruction multicycle CPU. Executes MULT, MULTU, DIV and DIVU over 32 shift iterations and owns the architectural HI/LO registers. Services MTHI/MTLO writes. The CPU control FSM pulses `start` in its EXE state and holds (stalls) while `busy` is high; MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_iter_core.sv | 53 +++++
 rtl/mdu_sequencer.sv | 156 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// sequencer states, iteration count and the divide-by-zero LO value.
package mdu_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [31:0] DZ_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two's-complement magnitude when en is set, raw value otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// 64-bit shift register with the per-iteration shift-add (multiply) or
// restoring subtract (divide) step. Operands arrive already as magnitudes.
module mdu_iter_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [63:0] acc
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;

  // Multiply: {partial product, multiplier} shifts right; divide:
  // {remainder, dividend/quotient} shifts left.
  always_comb begin
    acc_d     = acc_q;
    opb_d     = opb_q;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = acc_q[63:31];
    div_diff  = div_shift[31:0] - opb_q;
    if (load) begin
      acc_d = {32'd0, a_in};
      opb_d = b_in;
    end else if (step) begin
      if (is_div) begin
        if (div_shift >= {1'b0, opb_q}) acc_d = {div_diff, acc_q[30:0], 1'b1};
        else                            acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: accepts an op, runs ITER core iterations, fixes
// signs and commits HI/LO. Also owns the MTHI/MTLO write path.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz,
  output logic [1:0]  dbg_state
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          sgn_res_q, sgn_res_d;
  logic          sgn_rem_q, sgn_rem_d;
  logic          bz_q, bz_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;

  logic          accept;
  logic          signed_op;
  logic [63:0]   acc;
  logic [63:0]   prod;
  logic [31:0]   quo, rem;

  assign signed_op = ~op[0];
  assign accept    = start && (state_q == IDLE || state_q == DONE);

  mdu_iter_core u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (state_q == RUN),
    .is_div (is_div_q),
    .a_in   (abs32(a, signed_op)),
    .b_in   (abs32(b, signed_op)),
    .acc    (acc)
  );

  assign prod = sgn_res_q ? (~acc + 64'd1) : acc;
  assign quo  = sgn_res_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem  = sgn_rem_q ? (~acc[63:32] + 32'd1) : acc[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sgn_res_d = sgn_res_q;
    sgn_rem_d = sgn_rem_q;
    bz_d      = bz_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        state_d = IDLE;
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          sgn_res_d = signed_op & (a[31] ^ b[31]);
          sgn_rem_d = signed_op & a[31];
          bz_d      = (b == 32'd0);
          a_d       = a;
          dz_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q && bz_q) begin
          hi_d = a_q;
          lo_d = DZ_LO;
          dz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sgn_res_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      sgn_res_q <= sgn_res_d;
      sgn_rem_q <= sgn_rem_d;
      bz_q      <= bz_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dz        = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: scenario tasks drive ops, a scoreboard queue holds
// the expected {dz, hi, lo} of every launched op and is checked on done.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [64:0] exp_q[$];
  logic [64:0] sb_e;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dz        (dz),
    .dbg_state (dbg_state)
  );

  // Scoreboard: every done pulse pops one expected {dz, hi, lo}.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: done=1 with no pending op at %0t", $time);
      end else begin
        sb_e = exp_q.pop_front();
        if (hi !== sb_e[63:32]) begin
          bad++;
          $display("FAIL sb_hi: got %h want %h", hi, sb_e[63:32]);
        end
        total++;
        if (lo !== sb_e[31:0]) begin
          bad++;
          $display("FAIL sb_lo: got %h want %h", lo, sb_e[31:0]);
        end
        total++;
        if (dz !== sb_e[64]) begin
          bad++;
          $display("FAIL sb_dz: got %b want %b", dz, sb_e[64]);
        end
      end
    end
  end

  // Launch one op and return edges-to-done and busy cycle count (lat=-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [64:0] e, output int lat, output int bcnt);
    exp_q.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    bcnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL rst_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL rst_lo: got %h want 0", lo); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL rst_dz: got %b want 0", dz); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_multu_timing();
    int lat, bcnt;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, lat, bcnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL multu_latency: got %0d want 33", lat); end
    total++; if (bcnt !== 33) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 33", bcnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_in_done: got %b want 0", busy); end
    total++; if (dbg_state !== DONE) begin bad++; $display("FAIL multu_state_done: got %0d want 3", dbg_state); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, lat, bcnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
    run_op(OP_DIVU, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, lat, bcnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_divu_latency: got %0d want 33", lat); end
    total++; if (bcnt !== 33) begin bad++; $display("FAIL b2b_divu_busy: got %0d want 33", bcnt); end
  endtask

  task automatic test_div_signed();
    int lat, bcnt;
    logic [31:0] x, y;
    logic [63:0] p;
    logic signed [31:0] sq, sr;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, lat, bcnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL div_neg_latency: got %0d want 33", lat); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0, 32'h8000_0000}, lat, bcnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL div_ovf_latency: got %0d want 33", lat); end
    // Random operands against a behavioral model, two of each op.
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = $urandom;
      if (i[0]) y = y >> $urandom_range(0, 28);
      if (y == 32'd0) y = 32'd1;
      case (i[2:1])
        2'd0: begin
          p = 64'($signed(x)) * 64'($signed(y));
          run_op(OP_MULT, x, y, {1'b0, p}, lat, bcnt);
        end
        2'd1: begin
          p = {32'd0, x} * {32'd0, y};
          run_op(OP_MULTU, x, y, {1'b0, p}, lat, bcnt);
        end
        2'd2: begin
          sq = $signed(x) / $signed(y);
          sr = $signed(x) % $signed(y);
          run_op(OP_DIV, x, y, {1'b0, sr, sq}, lat, bcnt);
        end
        default: run_op(OP_DIVU, x, y, {1'b0, x % y, x / y}, lat, bcnt);
      endcase
      total++; if (lat !== 33) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    run_op(OP_DIV, 32'h1234_5678, 32'd0, {1'b1, 32'h1234_5678, DZ_LO}, lat, bcnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL dz_latency: got %0d want 33", lat); end
    repeat (3) @(negedge clk);
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_sticky: got %b want 1", dz); end
    run_op(OP_MULTU, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, lat, bcnt);
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL dz_cleared: got %b want 0", dz); end
  endtask

  task automatic test_mt_writes();
    int lat;
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 lo_we = 1'b0;
    @(negedge clk);
    total++; if (lo !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mtlo: got %h want deadbeef", lo); end
    hi_we = 1'b1; wdata = 32'h1111_2222;
    @(posedge clk);
    #1 hi_we = 1'b0;
    @(negedge clk);
    total++; if (hi !== 32'h1111_2222) begin bad++; $display("FAIL mthi: got %h want 11112222", hi); end
    exp_q.push_back({1'b0, 32'd0, 32'd30});
    op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (n == 5) begin
        hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
      end
      if (n == 6) begin
        hi_we = 1'b0; start = 1'b0;
        total++; if (hi !== 32'h1111_2222) begin bad++; $display("FAIL mthi_busy_ignored: got %h want 11112222", hi); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_during_run: got %b want 1", busy); end
      end
    end
    total++; if (lat !== 33) begin bad++; $display("FAIL run_start_ignored_latency: got %0d want 33", lat); end
  endtask

  task automatic test_reset_midrun();
    int lat, bcnt, ndone;
    op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL midrst_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL midrst_lo: got %h want 0", lo); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_late_done: got %0d want 0", ndone); end
    run_op(OP_MULTU, 32'd9, 32'd9, {1'b0, 32'd0, 32'd81}, lat, bcnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL after_rst_latency: got %0d want 33", lat); end
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_mt_writes();
    test_reset_midrun();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_pending: got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
